vend_dispense_sequencer: RTL and testbench
==========================================

Name: vend_dispense_sequencer

Overview:
Sequences one vending transaction end to end: accumulates coin credit, requests a bottle from the dispenser motor over a req/ack handshake, then returns change one coin per cycle. Tracks stock, rejects coins it cannot accept, and refunds on cancel or dispenser timeout. Sits between the coin acceptor front end and the dispenser/change-hopper drivers.

Parameters:
PRICE, 3, bottle price in 5-rupee units (3 = Rs 15)
STOCK_INIT, 8, stock count loaded on reset and on refill
STOCK_W, 4, stock counter width
ACK_TIMEOUT, 15, cycles to wait for disp_ack before aborting

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
coin  in  2  coin code: 01 = Rs 5, 10 = Rs 10, 00 = none, 11 = invalid
coin_valid  in  1  coin present this cycle
cancel  in  1  user cancel request (level, sampled each cycle)
refill  in  1  load stock to STOCK_INIT
disp_ack  in  1  dispenser has released bottle
disp_req  out  1  dispense request, held until ack or timeout
out_bottle  out  1  one-cycle pulse on successful dispense
out_change  out  2  one-cycle coin return: 01 = Rs 5, 10 = Rs 10, 00 = none
coin_reject  out  1  one-cycle pulse: last offered coin returned unaccepted
sold_out  out  1  stock == 0
fault  out  1  sticky; set on dispense timeout, cleared by rst only
credit  out  3  current credit in Rs 5 units

Behaviour:
- Synchronous active-high reset: state IDLE, credit 0, stock STOCK_INIT, timer 0, all outputs 0, fault 0.
- Credit width 3 bits; max reachable = PRICE+1 (Rs 20 for default); no overflow by construction.
- States: IDLE, COLLECT, VEND, CHANGE, REFUND.
- IDLE/COLLECT, coin_valid with 01/10 and stock > 0: credit += 1/2 next cycle; state COLLECT. If new credit >= PRICE, next state VEND, disp_req asserted the cycle after the coin is sampled (1-cycle latency).
- Coin 11, coin while sold_out, or any coin in VEND/CHANGE/REFUND: coin_reject pulses the next cycle; credit unchanged.
- VEND: disp_req = 1; timer counts cycles. On disp_req && disp_ack: out_bottle pulses next cycle, stock -= 1, credit -= PRICE; go CHANGE if remainder > 0, else IDLE; disp_req drops same edge.
- Timeout: timer reaches ACK_TIMEOUT without ack -> disp_req drops, fault = 1, stock unchanged, credit kept in full, go REFUND.
- CHANGE and REFUND identical mechanics: each cycle out_change = 10 if credit >= 2 else 01; credit decrements by 2 or 1; when credit reaches 0 go IDLE (out_change 00 thereafter).
- cancel in COLLECT -> REFUND next cycle; cancel in IDLE, VEND, CHANGE, REFUND ignored.
- cancel and coin_valid same cycle in COLLECT: cancel wins, coin rejected, refund of prior credit only.
- Coin that brings credit to >= PRICE in same cycle as cancel: cancel wins (coin rejected).
- refill honoured only in IDLE; ignored elsewhere. sold_out = (stock == 0), combinational from stock register.
- disp_ack outside VEND ignored.
- rst mid-transaction: credit discarded, no change issued, stock reloaded.

Test Plan:
- Rst, then 01 then 10 on consecutive cycles -> credit 1,3; disp_req next cycle; ack after 2 cycles -> out_bottle pulse, out_change stays 00, stock 7, IDLE.
- 10, 10 -> credit 4; ack -> out_bottle, then out_change=01 for one cycle, credit 0.
- 01, then cancel -> REFUND, out_change=01 one cycle; no out_bottle; stock unchanged.
- 10, 01, never ack -> disp_req held exactly 15 cycles, then fault=1, out_change=10 then 01, credit 0.
- Refill off, eight vends -> sold_out=1; further 01 -> coin_reject pulse, credit 0; refill in IDLE -> stock 8, sold_out=0.
- Coin 11 in IDLE -> coin_reject; coin 01 during VEND -> coin_reject, credit unchanged; cancel + coin same cycle -> refund prior credit only.

Source files
------------

// File: rtl/vend_dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vend_dispense_sequencer
// Purpose  : Sequences one vending transaction. Accumulates coin credit,
//            requests a bottle over a req/ack handshake with timeout, then
//            pays out change (or a refund) one coin per cycle. Tracks stock
//            and rejects coins that cannot be accepted.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            coin_i[1:0]     - 01 = Rs 5, 10 = Rs 10, 00 = none, 11 = invalid
//            coin_valid_i    - coin present this cycle
//            cancel_i        - user cancel (level)
//            refill_i        - reload stock (honoured in IDLE only)
//            disp_ack_i      - dispenser released the bottle
//            disp_req_o      - dispense request
//            out_bottle_o    - one-cycle pulse on successful dispense
//            out_change_o    - one-cycle coin return code (01/10/00)
//            coin_reject_o   - one-cycle pulse, offered coin returned
//            sold_out_o      - stock is zero
//            fault_o         - sticky dispense-timeout flag
//            credit_o[2:0]   - current credit in Rs 5 units
// Revision : 1.0 - initial release
// ============================================================================
module vend_dispense_sequencer #(
  parameter int PRICE       = 3,
  parameter int STOCK_INIT  = 8,
  parameter int STOCK_W     = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         coin_i,
  input  logic               coin_valid_i,
  input  logic               cancel_i,
  input  logic               refill_i,
  input  logic               disp_ack_i,
  output logic               disp_req_o,
  output logic               out_bottle_o,
  output logic [1:0]         out_change_o,
  output logic               coin_reject_o,
  output logic               sold_out_o,
  output logic               fault_o,
  output logic [2:0]         credit_o
);

  localparam int                 c_timer_w      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [2:0]         c_price        = 3'(PRICE);
  localparam logic [STOCK_W-1:0] c_stock_init   = STOCK_W'(STOCK_INIT);
  localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VEND    = 3'd2,
    S_CHANGE  = 3'd3,
    S_REFUND  = 3'd4
  } state_t;

  state_t               state_q;
  logic [2:0]           credit_q;
  logic [STOCK_W-1:0]   stock_q;
  logic [c_timer_w-1:0] timer_q;
  logic                 disp_req_q;
  logic                 out_bottle_q;
  logic [1:0]           out_change_q;
  logic                 coin_reject_q;
  logic                 fault_q;

  // Code 00 with coin_valid carries no value, so it is treated as no coin.
  logic       coin_present_d;
  logic       coin_ok_d;
  logic [2:0] credit_sum_d;
  logic [1:0] change_coin_d;
  logic [2:0] credit_paid_d;

  // The coin code doubles as its value in Rs 5 units (01 -> 1, 10 -> 2).
  assign coin_present_d = coin_valid_i && (coin_i != 2'b00);
  assign coin_ok_d      = (coin_i != 2'b11) && (stock_q != '0);
  assign credit_sum_d   = credit_q + {1'b0, coin_i};
  assign change_coin_d  = (credit_q >= 3'd2) ? 2'b10 : 2'b01;
  assign credit_paid_d  = credit_q - {1'b0, change_coin_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      stock_q       <= c_stock_init;
      timer_q       <= '0;
      disp_req_q    <= 1'b0;
      out_bottle_q  <= 1'b0;
      out_change_q  <= 2'b00;
      coin_reject_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      out_bottle_q  <= 1'b0;
      out_change_q  <= 2'b00;
      coin_reject_q <= 1'b0;

      case (state_q)
        S_IDLE, S_COLLECT: begin
          if ((state_q == S_COLLECT) && cancel_i) begin
            // Cancel outranks a coin offered in the same cycle.
            coin_reject_q <= coin_present_d;
            state_q       <= S_REFUND;
          end else if (coin_present_d) begin
            if (!coin_ok_d) begin
              coin_reject_q <= 1'b1;
            end else begin
              credit_q <= credit_sum_d;
              if (credit_sum_d >= c_price) begin
                state_q    <= S_VEND;
                disp_req_q <= 1'b1;
                timer_q    <= '0;
              end else begin
                state_q <= S_COLLECT;
              end
            end
          end
          // The coin check above uses the pre-refill stock.
          if ((state_q == S_IDLE) && refill_i) begin
            stock_q <= c_stock_init;
          end
        end

        S_VEND: begin
          coin_reject_q <= coin_present_d;
          if (disp_ack_i) begin
            // Ack wins even on the final timer cycle.
            out_bottle_q <= 1'b1;
            stock_q      <= stock_q - 1'b1;
            credit_q     <= credit_q - c_price;
            disp_req_q   <= 1'b0;
            state_q      <= (credit_q > c_price) ? S_CHANGE : S_IDLE;
          end else if (timer_q == c_timer_last) begin
            disp_req_q <= 1'b0;
            fault_q    <= 1'b1;
            state_q    <= S_REFUND;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        S_CHANGE, S_REFUND: begin
          coin_reject_q <= coin_present_d;
          if (credit_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            out_change_q <= change_coin_d;
            credit_q     <= credit_paid_d;
            if (credit_paid_d == '0) begin
              state_q <= S_IDLE;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign disp_req_o    = disp_req_q;
  assign out_bottle_o  = out_bottle_q;
  assign out_change_o  = out_change_q;
  assign coin_reject_o = coin_reject_q;
  assign sold_out_o    = (stock_q == '0);
  assign fault_o       = fault_q;
  assign credit_o      = credit_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_dispense_sequencer
// Purpose  : Self-checking bench for vend_dispense_sequencer. Directed
//            scenarios check fixed expected values; a randomized run checks
//            every output against a transaction-level reference model that
//            plans payouts as a queue of coins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_dispense_sequencer;

  localparam int PRICE       = 3;
  localparam int STOCK_INIT  = 8;
  localparam int STOCK_W     = 4;
  localparam int ACK_TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin;
  logic       coin_valid;
  logic       cancel;
  logic       refill;
  logic       disp_ack;
  logic       disp_req;
  logic       out_bottle;
  logic [1:0] out_change;
  logic       coin_reject;
  logic       sold_out;
  logic       fault;
  logic [2:0] credit;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vend_dispense_sequencer #(
    .PRICE      (PRICE),
    .STOCK_INIT (STOCK_INIT),
    .STOCK_W    (STOCK_W),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_i       (coin),
    .coin_valid_i (coin_valid),
    .cancel_i     (cancel),
    .refill_i     (refill),
    .disp_ack_i   (disp_ack),
    .disp_req_o   (disp_req),
    .out_bottle_o (out_bottle),
    .out_change_o (out_change),
    .coin_reject_o(coin_reject),
    .sold_out_o   (sold_out),
    .fault_o      (fault),
    .credit_o     (credit)
  );

  // ---------------- reference model ----------------
  // Phases: taking money, waiting on the dispenser, paying coins back.
  localparam int P_IDLE = 0, P_COLLECT = 1, P_WAIT = 2, P_PAY = 3;
  int m_phase, m_credit, m_stock, m_wait;
  bit m_fault;
  int m_payq[$];
  bit e_req, e_bottle, e_reject;
  int e_change;

  task automatic model_reset();
    m_phase = P_IDLE; m_credit = 0; m_stock = STOCK_INIT; m_wait = 0;
    m_fault = 0; m_payq.delete();
    e_req = 0; e_bottle = 0; e_reject = 0; e_change = 0;
  endtask

  // Plan the whole payout up front: as many Rs 10 as fit, then one Rs 5.
  task automatic start_pay();
    int n;
    m_payq.delete();
    n = m_credit;
    while (n >= 2) begin m_payq.push_back(2); n -= 2; end
    if (n > 0) m_payq.push_back(1);
    m_phase = (m_payq.size() == 0) ? P_IDLE : P_PAY;
  endtask

  task automatic model_step(input logic [1:0] c, input logic v, input logic cn,
                            input logic rf, input logic ak);
    bit present;
    int ph;
    present  = v && (c != 2'b00);
    ph       = m_phase;
    e_bottle = 0; e_change = 0; e_reject = 0;
    if (ph == P_IDLE || ph == P_COLLECT) begin
      if (ph == P_COLLECT && cn) begin
        e_reject = present;
        start_pay();
      end else if (present) begin
        if (c == 2'b11 || m_stock == 0) e_reject = 1;
        else begin
          m_credit += int'(c);
          if (m_credit >= PRICE) begin
            m_phase = P_WAIT; m_wait = 0; e_req = 1;
          end else m_phase = P_COLLECT;
        end
      end
      if (ph == P_IDLE && rf) m_stock = STOCK_INIT;
    end else if (ph == P_WAIT) begin
      e_reject = present;
      if (ak) begin
        e_bottle = 1; e_req = 0; m_stock -= 1; m_credit -= PRICE;
        start_pay();
      end else begin
        m_wait += 1;
        if (m_wait == ACK_TIMEOUT) begin
          e_req = 0; m_fault = 1;
          start_pay();
        end
      end
    end else begin
      e_reject = present;
      e_change = m_payq.pop_front();
      m_credit -= e_change;
      if (m_payq.size() == 0) m_phase = P_IDLE;
    end
  endtask

  // ---------------- stimulus primitives ----------------
  task automatic step(input logic [1:0] c, input logic v, input logic cn,
                      input logic rf, input logic ak);
    coin = c; coin_valid = v; cancel = cn; refill = rf; disp_ack = ak;
    model_step(c, v, cn, rf, ak);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    coin = 2'b00; coin_valid = 1'b0; cancel = 1'b0; refill = 1'b0; disp_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    coin = 2'b01; coin_valid = 1'b1; cancel = 1'b1; refill = 1'b0; disp_ack = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (credit !== 3'd0) begin n_errors++; $display("FAIL reset_credit got %0d want 0", credit); end
    n_checks++;
    if ({disp_req, out_bottle, out_change, coin_reject} !== 5'b0) begin
      n_errors++; $display("FAIL reset_outputs got %b want 00000", {disp_req, out_bottle, out_change, coin_reject});
    end
    n_checks++;
    if ({sold_out, fault} !== 2'b00) begin n_errors++; $display("FAIL reset_flags got %b want 00", {sold_out, fault}); end
    rst = 1'b0;
    model_reset();
    idle_step();
  endtask

  task automatic test_basic_vend();
    do_reset();
    step(2'b01, 1, 0, 0, 0);
    n_checks++;
    if (credit !== 3'd1) begin n_errors++; $display("FAIL basic_credit1 got %0d want 1", credit); end
    step(2'b10, 1, 0, 0, 0);
    n_checks++;
    if (credit !== 3'd3 || disp_req !== 1'b1) begin
      n_errors++; $display("FAIL basic_credit3_req got credit %0d req %b want 3 1", credit, disp_req);
    end
    idle_step();
    n_checks++;
    if (disp_req !== 1'b1) begin n_errors++; $display("FAIL basic_req_held got %b want 1", disp_req); end
    step(2'b00, 0, 0, 0, 1);
    n_checks++;
    if (out_bottle !== 1'b1 || disp_req !== 1'b0 || credit !== 3'd0 || out_change !== 2'b00) begin
      n_errors++; $display("FAIL basic_dispense got bottle %b req %b credit %0d change %b want 1 0 0 00",
                           out_bottle, disp_req, credit, out_change);
    end
    idle_step();
    n_checks++;
    if (out_bottle !== 1'b0 || out_change !== 2'b00) begin
      n_errors++; $display("FAIL basic_after got bottle %b change %b want 0 00", out_bottle, out_change);
    end
  endtask

  task automatic test_change();
    do_reset();
    step(2'b10, 1, 0, 0, 0);
    step(2'b10, 1, 0, 0, 0);
    n_checks++;
    if (credit !== 3'd4 || disp_req !== 1'b1) begin
      n_errors++; $display("FAIL change_credit4 got credit %0d req %b want 4 1", credit, disp_req);
    end
    step(2'b00, 0, 0, 0, 1);
    n_checks++;
    if (out_bottle !== 1'b1 || credit !== 3'd1) begin
      n_errors++; $display("FAIL change_dispense got bottle %b credit %0d want 1 1", out_bottle, credit);
    end
    idle_step();
    n_checks++;
    if (out_change !== 2'b01 || credit !== 3'd0) begin
      n_errors++; $display("FAIL change_coin got change %b credit %0d want 01 0", out_change, credit);
    end
    idle_step();
    n_checks++;
    if (out_change !== 2'b00) begin n_errors++; $display("FAIL change_end got %b want 00", out_change); end
  endtask

  task automatic test_cancel();
    do_reset();
    step(2'b01, 1, 0, 0, 0);
    step(2'b00, 0, 1, 0, 0);
    idle_step();
    n_checks++;
    if (out_change !== 2'b01 || credit !== 3'd0 || out_bottle !== 1'b0) begin
      n_errors++; $display("FAIL cancel_refund got change %b credit %0d bottle %b want 01 0 0",
                           out_change, credit, out_bottle);
    end
    idle_step();
    n_checks++;
    if (out_change !== 2'b00 || sold_out !== 1'b0) begin
      n_errors++; $display("FAIL cancel_end got change %b sold_out %b want 00 0", out_change, sold_out);
    end
  endtask

  task automatic test_timeout();
    int hi;
    do_reset();
    step(2'b10, 1, 0, 0, 0);
    step(2'b01, 1, 0, 0, 0);
    hi = (disp_req === 1'b1) ? 1 : 0;
    for (int i = 0; i < 2 * ACK_TIMEOUT; i++) begin
      idle_step();
      if (disp_req !== 1'b1) break;
      hi++;
    end
    n_checks++;
    if (hi != ACK_TIMEOUT) begin n_errors++; $display("FAIL timeout_req_cycles got %0d want %0d", hi, ACK_TIMEOUT); end
    n_checks++;
    if (fault !== 1'b1 || credit !== 3'd3 || out_bottle !== 1'b0) begin
      n_errors++; $display("FAIL timeout_fault got fault %b credit %0d bottle %b want 1 3 0", fault, credit, out_bottle);
    end
    idle_step();
    n_checks++;
    if (out_change !== 2'b10 || credit !== 3'd1) begin
      n_errors++; $display("FAIL timeout_refund10 got change %b credit %0d want 10 1", out_change, credit);
    end
    idle_step();
    n_checks++;
    if (out_change !== 2'b01 || credit !== 3'd0) begin
      n_errors++; $display("FAIL timeout_refund05 got change %b credit %0d want 01 0", out_change, credit);
    end
    idle_step();
    n_checks++;
    if (out_change !== 2'b00 || fault !== 1'b1) begin
      n_errors++; $display("FAIL timeout_sticky got change %b fault %b want 00 1", out_change, fault);
    end
  endtask

  task automatic test_sold_out();
    do_reset();
    for (int k = 0; k < STOCK_INIT; k++) begin
      step(2'b10, 1, 0, 0, 0);
      step(2'b01, 1, 0, 0, 0);
      step(2'b00, 0, 0, 0, 1);
      if (k == STOCK_INIT - 2) begin
        n_checks++;
        if (sold_out !== 1'b0) begin n_errors++; $display("FAIL soldout_early got %b want 0", sold_out); end
      end
    end
    n_checks++;
    if (sold_out !== 1'b1) begin n_errors++; $display("FAIL soldout_set got %b want 1", sold_out); end
    step(2'b01, 1, 0, 0, 0);
    n_checks++;
    if (coin_reject !== 1'b1 || credit !== 3'd0) begin
      n_errors++; $display("FAIL soldout_reject got reject %b credit %0d want 1 0", coin_reject, credit);
    end
    step(2'b00, 0, 0, 1, 0);
    n_checks++;
    if (sold_out !== 1'b0 || coin_reject !== 1'b0) begin
      n_errors++; $display("FAIL soldout_refill got sold_out %b reject %b want 0 0", sold_out, coin_reject);
    end
  endtask

  task automatic test_reject();
    do_reset();
    step(2'b11, 1, 0, 0, 0);
    n_checks++;
    if (coin_reject !== 1'b1 || credit !== 3'd0) begin
      n_errors++; $display("FAIL rej_invalid got reject %b credit %0d want 1 0", coin_reject, credit);
    end
    step(2'b10, 1, 0, 0, 0);
    n_checks++;
    if (coin_reject !== 1'b0 || credit !== 3'd2) begin
      n_errors++; $display("FAIL rej_pulse_end got reject %b credit %0d want 0 2", coin_reject, credit);
    end
    step(2'b01, 1, 0, 0, 0);
    step(2'b01, 1, 0, 0, 0);
    n_checks++;
    if (coin_reject !== 1'b1 || credit !== 3'd3 || disp_req !== 1'b1) begin
      n_errors++; $display("FAIL rej_in_vend got reject %b credit %0d req %b want 1 3 1", coin_reject, credit, disp_req);
    end
    step(2'b00, 0, 0, 1, 1);
    // Cancel with a coin: only the earlier Rs 5 comes back.
    step(2'b01, 1, 0, 0, 0);
    step(2'b10, 1, 1, 0, 0);
    n_checks++;
    if (coin_reject !== 1'b1 || credit !== 3'd1) begin
      n_errors++; $display("FAIL rej_cancel_coin got reject %b credit %0d want 1 1", coin_reject, credit);
    end
    idle_step();
    n_checks++;
    if (out_change !== 2'b01 || credit !== 3'd0) begin
      n_errors++; $display("FAIL rej_cancel_refund got change %b credit %0d want 01 0", out_change, credit);
    end
    // A coin that would reach the price loses to cancel.
    step(2'b10, 1, 0, 0, 0);
    step(2'b01, 1, 1, 0, 0);
    n_checks++;
    if (coin_reject !== 1'b1 || disp_req !== 1'b0 || credit !== 3'd2) begin
      n_errors++; $display("FAIL rej_cancel_price got reject %b req %b credit %0d want 1 0 2", coin_reject, disp_req, credit);
    end
    idle_step();
    n_checks++;
    if (out_change !== 2'b10 || credit !== 3'd0) begin
      n_errors++; $display("FAIL rej_cancel_price_refund got change %b credit %0d want 10 0", out_change, credit);
    end
  endtask

  task automatic test_random();
    logic [1:0] c;
    logic v, cn, rf, ak;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      c  = 2'($urandom_range(0, 3));
      v  = ($urandom_range(0, 99) < 45);
      cn = ($urandom_range(0, 99) < 8);
      rf = ($urandom_range(0, 99) < 3);
      ak = ($urandom_range(0, 99) < 12);
      step(c, v, cn, rf, ak);
      n_checks++;
      if (credit !== 3'(m_credit)) begin
        n_errors++; $display("FAIL rnd_credit cyc %0d got %0d want %0d", cyc, credit, m_credit);
      end
      n_checks++;
      if (disp_req !== e_req || out_bottle !== e_bottle) begin
        n_errors++; $display("FAIL rnd_vend cyc %0d got req %b bottle %b want %b %b", cyc, disp_req, out_bottle, e_req, e_bottle);
      end
      n_checks++;
      if (out_change !== 2'(e_change) || coin_reject !== e_reject) begin
        n_errors++; $display("FAIL rnd_coins cyc %0d got change %b reject %b want %0d %b", cyc, out_change, coin_reject, e_change, e_reject);
      end
      n_checks++;
      if (sold_out !== (m_stock == 0) || fault !== m_fault) begin
        n_errors++; $display("FAIL rnd_flags cyc %0d got sold_out %b fault %b want stock %0d fault %b", cyc, sold_out, fault, m_stock, m_fault);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_vend();
    test_change();
    test_cancel();
    test_timeout();
    test_sold_out();
    test_reject();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
